// File: rtl/can_frame_to_ascii.sv
// can_frame_to_ascii: formats one CAN frame (ID, DLC, payload) as an ASCII
// text line and streams it byte by byte into a UART TX FIFO using wreq/wgnt.
// Line: [SEQ ' '] ID ' ' LEN [' ' DATA] EOL
// Optional feature macro: CAN_FMT_SEQNUM_EN adds a 4-digit frame sequence prefix.
module can_frame_to_ascii #(
  parameter int HEX_UPPER = 1,
  parameter int EOL_CRLF  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_ide,
  input  logic [28:0] i_id,
  input  logic [3:0]  i_len,
  input  logic [63:0] i_data,
  output logic        wreq,
  input  logic        wgnt,
  output logic [7:0]  wdata,
  output logic        o_busy
);

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
`ifdef CAN_FMT_SEQNUM_EN
    ST_SEQ  = 4'd1,
`endif
    ST_ID   = 4'd2,
    ST_SP1  = 4'd3,
    ST_LEN  = 4'd4,
    ST_SP2  = 4'd5,
    ST_DATA = 4'd6,
    ST_CR   = 4'd7,
    ST_LF   = 4'd8
  } state_t;

  // First end-of-line state: CR then LF, or LF alone.
  localparam state_t ST_EOL = (EOL_CRLF != 0) ? ST_CR : ST_LF;

  state_t      state_r;
  state_t      nxt_state_s;
  logic [3:0]  nib_r;
  logic [3:0]  nxt_nib_s;
  logic        wreq_r;
  logic [7:0]  wdata_r;
  logic        ready_r;
  logic [7:0]  nxt_char_s;

  logic        ide_r;
  logic [28:0] id_r;
  logic [3:0]  len_r;
  logic [63:0] data_r;

  logic        acc_s;
  logic        adv_s;
  logic [3:0]  len_clamp_s;
  logic [28:0] id_mask_s;
  logic [28:0] src_id_s;
  logic [3:0]  src_len_s;
  logic [63:0] src_data_s;

  // One nibble to its ASCII hex digit.
  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    logic [7:0] ch;
    if (nib < 4'd10) begin
      ch = 8'h30 + {4'h0, nib};
    end else if (HEX_UPPER != 0) begin
      ch = 8'h37 + {4'h0, nib};
    end else begin
      ch = 8'h57 + {4'h0, nib};
    end
    return ch;
  endfunction

  // Character emitted in a given state/nibble position (SEQ handled separately).
  // DATA nibble index n: byte n/2, high nibble on even n.
  function automatic logic [7:0] char_at(input state_t st, input logic [3:0] nib,
                                         input logic [28:0] id, input logic [3:0] len,
                                         input logic [63:0] data);
    logic [31:0] id32;
    logic [7:0]  ch;
    id32 = {3'b000, id};
    case (st)
      ST_ID:          ch = hex_char(id32[{nib[2:0], 2'b00} +: 4]);
      ST_SP1, ST_SP2: ch = 8'h20;
      ST_LEN:         ch = hex_char(len);
      ST_DATA:        ch = hex_char(data[{nib[3:1], ~nib[0], 2'b00} +: 4]);
      ST_CR:          ch = 8'h0D;
      ST_LF:          ch = 8'h0A;
      default:        ch = 8'h00;
    endcase
    return ch;
  endfunction

  assign acc_s       = i_valid & ready_r;
  assign adv_s       = wreq_r & wgnt;
  assign len_clamp_s = (i_len > 4'd8) ? 4'd8 : i_len;
  assign id_mask_s   = i_ide ? i_id : {18'd0, i_id[10:0]};

  // During the accept cycle the first character comes from the live inputs.
  assign src_id_s   = acc_s ? id_mask_s   : id_r;
  assign src_len_s  = acc_s ? len_clamp_s : len_r;
  assign src_data_s = acc_s ? i_data      : data_r;

`ifdef CAN_FMT_SEQNUM_EN
  logic [15:0] seq_r;
  logic [15:0] seq_lat_r;
  logic [15:0] src_seq_s;
  assign src_seq_s = acc_s ? seq_r : seq_lat_r;
`endif

  // Next state and nibble position; moves only on accept or on a granted byte.
  always_comb begin
    nxt_state_s = state_r;
    nxt_nib_s   = nib_r;
    if (acc_s) begin
`ifdef CAN_FMT_SEQNUM_EN
      nxt_state_s = ST_SEQ;
      nxt_nib_s   = 4'd3;
`else
      nxt_state_s = ST_ID;
      nxt_nib_s   = i_ide ? 4'd7 : 4'd2;
`endif
    end else if (adv_s) begin
      case (state_r)
`ifdef CAN_FMT_SEQNUM_EN
        ST_SEQ: begin
          if (nib_r == 4'd0) begin
            nxt_state_s = ST_ID;
            nxt_nib_s   = ide_r ? 4'd7 : 4'd2;
          end else begin
            nxt_state_s = ST_SEQ;
            nxt_nib_s   = nib_r - 4'd1;
          end
        end
`endif
        ST_ID: begin
          if (nib_r == 4'd0) begin
            nxt_state_s = ST_SP1;
            nxt_nib_s   = 4'd0;
          end else begin
            nxt_state_s = ST_ID;
            nxt_nib_s   = nib_r - 4'd1;
          end
        end
        ST_SP1: begin
          nxt_state_s = ST_LEN;
          nxt_nib_s   = 4'd0;
        end
        ST_LEN: begin
          if (len_r == 4'd0) begin
            nxt_state_s = ST_EOL;
          end else begin
            nxt_state_s = ST_SP2;
          end
          nxt_nib_s = 4'd0;
        end
        ST_SP2: begin
          nxt_state_s = ST_DATA;
          nxt_nib_s   = 4'd0;
        end
        ST_DATA: begin
          if ({1'b0, nib_r} == ({len_r, 1'b0} - 5'd1)) begin
            nxt_state_s = ST_EOL;
            nxt_nib_s   = 4'd0;
          end else begin
            nxt_state_s = ST_DATA;
            nxt_nib_s   = nib_r + 4'd1;
          end
        end
        ST_CR: begin
          nxt_state_s = ST_LF;
          nxt_nib_s   = 4'd0;
        end
        ST_LF: begin
          nxt_state_s = ST_IDLE;
          nxt_nib_s   = 4'd0;
        end
        default: begin
          nxt_state_s = ST_IDLE;
          nxt_nib_s   = 4'd0;
        end
      endcase
    end else begin
      nxt_state_s = state_r;
      nxt_nib_s   = nib_r;
    end
  end

  // Character belonging to the next state; holding re-evaluates the same byte.
  always_comb begin
    nxt_char_s = char_at(nxt_state_s, nxt_nib_s, src_id_s, src_len_s, src_data_s);
`ifdef CAN_FMT_SEQNUM_EN
    if (nxt_state_s == ST_SEQ) begin
      nxt_char_s = hex_char(src_seq_s[{nxt_nib_s[1:0], 2'b00} +: 4]);
    end else begin
      nxt_char_s = char_at(nxt_state_s, nxt_nib_s, src_id_s, src_len_s, src_data_s);
    end
`endif
  end

  // FSM state and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      nib_r   <= 4'd0;
      wreq_r  <= 1'b0;
      wdata_r <= 8'h00;
      ready_r <= 1'b1;
    end else begin
      state_r <= nxt_state_s;
      nib_r   <= nxt_nib_s;
      wreq_r  <= (nxt_state_s != ST_IDLE);
      wdata_r <= nxt_char_s;
      ready_r <= (nxt_state_s == ST_IDLE);
    end
  end

  // Frame capture on accept; inputs are ignored for the rest of the line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ide_r  <= 1'b0;
      id_r   <= 29'd0;
      len_r  <= 4'd0;
      data_r <= 64'd0;
    end else if (acc_s) begin
      ide_r  <= i_ide;
      id_r   <= id_mask_s;
      len_r  <= len_clamp_s;
      data_r <= i_data;
    end
  end

`ifdef CAN_FMT_SEQNUM_EN
  // Sequence counter: the pre-increment value is latched and printed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_r     <= 16'h0000;
      seq_lat_r <= 16'h0000;
    end else if (acc_s) begin
      seq_lat_r <= seq_r;
      seq_r     <= seq_r + 16'h0001;
    end
  end
`endif

  assign wreq    = wreq_r;
  assign wdata   = wdata_r;
  assign o_ready = ready_r;
  assign o_busy  = ~ready_r;

endmodule

// File: tb/tb_can_frame_to_ascii.sv
// Testbench for can_frame_to_ascii: table vectors, hand sequences for stall,
// back-to-back and mid-line reset, then random frames against a string model.
// A second instance checks lowercase hex and LF-only line endings.
module tb_can_frame_to_ascii;

`ifdef CAN_FMT_SEQNUM_EN
  localparam bit SEQ_EN = 1'b1;
`else
  localparam bit SEQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        i_ide;
  logic [28:0] i_id;
  logic [3:0]  i_len;
  logic [63:0] i_data;
  logic        wgnt;
  logic        wgnt2;
  logic        o_ready, wreq, o_busy;
  logic [7:0]  wdata;
  logic        o_ready2, wreq2, o_busy2;
  logic [7:0]  wdata2;

  always #5 clk = ~clk;

  can_frame_to_ascii #(.HEX_UPPER(1), .EOL_CRLF(1)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_ide(i_ide), .i_id(i_id), .i_len(i_len), .i_data(i_data),
    .wreq(wreq), .wgnt(wgnt), .wdata(wdata), .o_busy(o_busy)
  );

  can_frame_to_ascii #(.HEX_UPPER(0), .EOL_CRLF(0)) dut2 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready2),
    .i_ide(i_ide), .i_id(i_id), .i_len(i_len), .i_data(i_data),
    .wreq(wreq2), .wgnt(wgnt2), .wdata(wdata2), .o_busy(o_busy2)
  );

  int    n_chk = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    acc_cyc = 0;
  int    acc_n = 0;
  int    first_gnt_cyc = -1;
  int    last_gnt_cyc = 0;
  int    gnt_mode = 0;
  bit    prev_hold = 1'b0;
  logic [7:0]  prev_data;
  logic [15:0] seq1 = 16'h0000;
  logic [15:0] seq2 = 16'h0000;
  string cap1 = "";
  string cap2 = "";

  task automatic chk(input string name, input bit ok, input string act, input string exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %s, expected %s", name, act, exp);
    end
  endtask

  function automatic string vis(input string s);
    string r = "";
    byte   c;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (c == 8'h0D) r = {r, "\\r"};
      else if (c == 8'h0A) r = {r, "\\n"};
      else r = $sformatf("%s%c", r, c);
    end
    return r;
  endfunction

  function automatic string hexs(input logic [31:0] v, input int n, input bit upper);
    string s = "";
    int    d;
    for (int i = n - 1; i >= 0; i--) begin
      d = int'((v >> (4 * i)) & 32'hF);
      if (d < 10) s = $sformatf("%s%c", s, 8'(48 + d));
      else s = $sformatf("%s%c", s, 8'((upper ? 65 : 97) + d - 10));
    end
    return s;
  endfunction

  function automatic string eol(input bit crlf);
    if (crlf) return $sformatf("%c%c", 8'h0D, 8'h0A);
    else return $sformatf("%c", 8'h0A);
  endfunction

  function automatic string pfx(input logic [15:0] seq, input bit upper);
    if (SEQ_EN) return {hexs({16'h0, seq}, 4, upper), " "};
    else return "";
  endfunction

  // Reference line built directly from the textual format rules.
  function automatic string model(input bit ide, input logic [28:0] id, input logic [3:0] len,
                                  input logic [63:0] data, input logic [15:0] seq,
                                  input bit upper, input bit crlf);
    string s;
    int    l;
    logic [31:0] v;
    s = pfx(seq, upper);
    v = ide ? {3'b000, id} : {21'd0, id[10:0]};
    s = {s, hexs(v, ide ? 8 : 3, upper), " "};
    l = (len > 4'd8) ? 8 : int'(len);
    s = {s, hexs(32'(l), 1, upper)};
    if (l > 0) begin
      s = {s, " "};
      for (int k = 0; k < l; k++) s = {s, hexs({24'h0, data[8*k +: 8]}, 2, upper)};
    end
    return {s, eol(crlf)};
  endfunction

  // Observer on the falling edge: byte capture, accept tracking, hold rules.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      seq1 = 16'h0000;
      seq2 = 16'h0000;
      prev_hold = 1'b0;
    end else begin
      if (i_valid && o_ready) begin
        acc_cyc = cyc;
        acc_n++;
        seq1 = seq1 + 16'h0001;
      end
      if (i_valid && o_ready2) seq2 = seq2 + 16'h0001;
      if (prev_hold)
        chk("stall hold", wreq && (wdata == prev_data),
            $sformatf("wreq=%0b wdata=%02h", wreq, wdata), $sformatf("wreq=1 wdata=%02h", prev_data));
      if (wreq && wgnt) begin
        cap1 = $sformatf("%s%c", cap1, wdata);
        last_gnt_cyc = cyc;
        if (first_gnt_cyc < 0) first_gnt_cyc = cyc;
      end
      if (wreq2) cap2 = $sformatf("%s%c", cap2, wdata2);
      chk("busy/ready", (o_busy == !o_ready) && !(wreq && o_ready),
          $sformatf("busy=%0b ready=%0b wreq=%0b", o_busy, o_ready, wreq), "busy=~ready, no wreq when ready");
      prev_hold = wreq && !wgnt;
      prev_data = wdata;
    end
  end

  // Grant driver: 0 always grant, 1 random, 2 left to the test sequence.
  initial begin
    wgnt = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (gnt_mode)
        0: wgnt = 1'b1;
        1: wgnt = 1'($urandom_range(0, 1));
        default: ;
      endcase
    end
  end

  task automatic scramble();
    i_ide  = 1'($urandom);
    i_id   = 29'($urandom);
    i_len  = 4'($urandom);
    i_data = {$urandom, $urandom};
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (!(o_ready && o_ready2) && t < 200) begin
      @(posedge clk); #1; t++;
    end
    chk({name, " idle wait"}, t < 200, $sformatf("%0d cycles", t), "<200 cycles");
  endtask

  task automatic run_line(input bit ide, input logic [28:0] id, input logic [3:0] len,
                          input logic [63:0] data, input int mode, input int hold_at,
                          input bit chk2, input string e1, input string e2, input string name);
    int  t;
    bit  held = 1'b0;
    byte hc;
    gnt_mode = mode;
    wait_idle(name);
    cap1 = ""; cap2 = ""; first_gnt_cyc = -1;
    i_valid = 1'b1; i_ide = ide; i_id = id; i_len = len; i_data = data;
    @(posedge clk); #1;
    chk({name, " latency"}, wreq && !o_ready, $sformatf("wreq=%0b ready=%0b", wreq, o_ready), "wreq=1 ready=0");
    i_valid = 1'b0;
    scramble();
    t = 0;
    while (cap1.len() < e1.len() && t < 400) begin
      if (hold_at >= 0 && cap1.len() == hold_at && !held) begin
        held = 1'b1;
        hc = e1[hold_at];
        gnt_mode = 2;
        wgnt = 1'b0;
        for (int k = 0; k < 5; k++) begin
          chk({name, " stalled byte"}, wreq && !o_ready && (wdata == hc),
              $sformatf("wreq=%0b ready=%0b wdata=%02h", wreq, o_ready, wdata), $sformatf("wreq=1 ready=0 wdata=%02h", hc));
          @(posedge clk); #1; t++;
        end
        gnt_mode = mode;
        wgnt = 1'b1;
      end
      @(posedge clk); #1; t++;
    end
    chk({name, " done"}, t < 400 && !wreq && o_ready, $sformatf("t=%0d wreq=%0b ready=%0b", t, wreq, o_ready), "wreq=0 ready=1");
    chk({name, " line"}, cap1 == e1, vis(cap1), vis(e1));
    if (chk2) begin
      wait_idle(name);
      chk({name, " line lc/lf"}, cap2 == e2, vis(cap2), vis(e2));
    end
  endtask

  typedef struct {
    bit          ide;
    logic [28:0] id;
    logic [3:0]  len;
    logic [63:0] data;
    string       body_uc;
    string       body_lc;
  } vec_t;

  vec_t  vecs[5];
  string e1, e2, ea, eb;
  int    n0, t;
  bit    r_ide;
  logic [28:0] r_id;
  logic [3:0]  r_len;
  logic [63:0] r_data;

  initial begin
    vecs[0] = '{1'b0, 29'h123, 4'd2, 64'hCDAB, "123 2 ABCD", "123 2 abcd"};
    vecs[1] = '{1'b1, 29'h0ABCDEF1, 4'd0, 64'h0, "0ABCDEF1 0", "0abcdef1 0"};
    vecs[2] = '{1'b0, 29'h7FF, 4'd15, 64'h0807060504030201, "7FF 8 0102030405060708", "7ff 8 0102030405060708"};
    vecs[3] = '{1'b0, 29'h1FFFFABC, 4'd1, 64'hEF, "2BC 1 EF", "2bc 1 ef"};
    vecs[4] = '{1'b1, 29'h1FFFFFFF, 4'd9, 64'hFEDCBA9876543210,
                "1FFFFFFF 8 1032547698BADCFE", "1fffffff 8 1032547698badcfe"};

    rst = 1'b1; i_valid = 1'b0; wgnt2 = 1'b1;
    i_ide = 1'b0; i_id = 29'd0; i_len = 4'd0; i_data = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset state", !wreq && wdata == 8'h00 && o_ready && !o_busy && o_ready2,
        $sformatf("wreq=%0b wdata=%02h ready=%0b busy=%0b", wreq, wdata, o_ready, o_busy), "wreq=0 wdata=00 ready=1 busy=0");
    rst = 1'b0;

    // Grants while idle must not produce any byte.
    gnt_mode = 1;
    repeat (6) @(posedge clk);
    #1;
    chk("idle no output", !wreq && o_ready && cap1.len() == 0, $sformatf("wreq=%0b bytes=%0d", wreq, cap1.len()), "wreq=0 bytes=0");

    // Table vectors with full grant.
    for (int i = 0; i < 5; i++) begin
      e1 = {pfx(seq1, 1'b1), vecs[i].body_uc, eol(1'b1)};
      e2 = {pfx(seq2, 1'b0), vecs[i].body_lc, eol(1'b0)};
      run_line(vecs[i].ide, vecs[i].id, vecs[i].len, vecs[i].data, 0, -1, 1'b1, e1, e2, $sformatf("vec%0d", i));
      if (i == 0)
        chk("vec0 back-to-back grants", (first_gnt_cyc == acc_cyc + 1) && (last_gnt_cyc - first_gnt_cyc == e1.len() - 1),
            $sformatf("first=%0d last=%0d acc=%0d", first_gnt_cyc, last_gnt_cyc, acc_cyc), "consecutive from accept+1");
    end

    // Stall on the 4th byte (the first space) for 5 cycles.
    e1 = {pfx(seq1, 1'b1), "123 2 ABCD", eol(1'b1)};
    e2 = {pfx(seq2, 1'b0), "123 2 abcd", eol(1'b0)};
    run_line(1'b0, 29'h123, 4'd2, 64'hCDAB, 0, SEQ_EN ? 8 : 3, 1'b1, e1, e2, "stall");

    // Back-to-back frames with i_valid held high.
    gnt_mode = 0;
    wait_idle("b2b");
    cap1 = ""; n0 = acc_n;
    ea = model(1'b0, 29'h123, 4'd2, 64'hCDAB, seq1, 1'b1, 1'b1);
    i_valid = 1'b1; i_ide = 1'b0; i_id = 29'h123; i_len = 4'd2; i_data = 64'hCDAB;
    @(posedge clk); #1;
    eb = model(1'b1, 29'h0ABCDEF1, 4'd0, 64'h0, seq1, 1'b1, 1'b1);
    i_ide = 1'b1; i_id = 29'h0ABCDEF1; i_len = 4'd0; i_data = 64'h0;
    t = 0;
    while (acc_n < n0 + 2 && t < 200) begin
      @(posedge clk); #1; t++;
    end
    i_valid = 1'b0;
    chk("b2b accept after LF", t < 200 && acc_cyc == last_gnt_cyc + 1,
        $sformatf("accept=%0d lf=%0d", acc_cyc, last_gnt_cyc), "accept = LF grant + 1");
    t = 0;
    while (cap1.len() < ea.len() + eb.len() && t < 200) begin
      @(posedge clk); #1; t++;
    end
    chk("b2b lines", cap1 == {ea, eb}, vis(cap1), vis({ea, eb}));

    // Reset in the middle of a line.
    wait_idle("rst");
    cap1 = "";
    i_valid = 1'b1; i_ide = 1'b0; i_id = 29'h7FF; i_len = 4'd8; i_data = 64'h0807060504030201;
    @(posedge clk); #1;
    i_valid = 1'b0;
    t = 0;
    while (cap1.len() < 5 && t < 100) begin
      @(posedge clk); #1; t++;
    end
    rst = 1'b1;
    #1;
    chk("mid-line reset", !wreq && o_ready && wdata == 8'h00,
        $sformatf("wreq=%0b ready=%0b wdata=%02h", wreq, o_ready, wdata), "wreq=0 ready=1 wdata=00");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("no EOL after reset", !wreq && cap1.len() == 5, $sformatf("wreq=%0b bytes=%0d", wreq, cap1.len()), "wreq=0 bytes=5");
    e1 = {pfx(seq1, 1'b1), "123 2 ABCD", eol(1'b1)};
    e2 = {pfx(seq2, 1'b0), "123 2 abcd", eol(1'b0)};
    run_line(1'b0, 29'h123, 4'd2, 64'hCDAB, 0, -1, 1'b1, e1, e2, "after reset");

`ifdef CAN_FMT_SEQNUM_EN
    // Counter wrap FFFF -> 0000 on the main instance.
    wait_idle("wrap");
    force dut.seq_r = 16'hFFFF;
    @(posedge clk); #1;
    release dut.seq_r;
    seq1 = 16'hFFFF;
    run_line(1'b0, 29'h123, 4'd2, 64'hCDAB, 0, -1, 1'b0, {"FFFF 123 2 ABCD", eol(1'b1)}, "", "wrap ffff");
    run_line(1'b0, 29'h123, 4'd2, 64'hCDAB, 0, -1, 1'b0, {"0000 123 2 ABCD", eol(1'b1)}, "", "wrap 0000");
`endif

    // Random frames with random grant back-pressure.
    for (int n = 0; n < 30; n++) begin
      r_ide  = 1'($urandom);
      r_id   = 29'($urandom);
      r_len  = 4'($urandom_range(0, 15));
      r_data = {$urandom, $urandom};
      wait_idle("rand");
      e1 = model(r_ide, r_id, r_len, r_data, seq1, 1'b1, 1'b1);
      e2 = model(r_ide, r_id, r_len, r_data, seq2, 1'b0, 1'b0);
      run_line(r_ide, r_id, r_len, r_data, int'($urandom_range(0, 1)), -1, 1'b1, e1, e2, $sformatf("rand%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
